// File: rtl/h264invdc_transform_if.sv
// Handshake bundle for the H.264 chroma DC inverse transform.
// master = surrounding logic (producer+consumer), slave = transform.
interface h264invdc_transform_if;
   logic        READYI;
   logic        ENABLE;
   logic [15:0] XXIN;
   logic        VALID;
   logic [15:0] YYOUT;
   logic        READYO;

   modport master (
      input  READYI, VALID, YYOUT,
      output ENABLE, XXIN, READYO
   );

   modport slave (
      output READYI, VALID, YYOUT,
      input  ENABLE, XXIN, READYO
   );
endinterface

// File: rtl/h264invdc_transform.sv
// H.264 2x2 chroma DC inverse transform, LOAD/CALC/OUT FSM.
// Define H264_INVDC_SATURATE_EN to saturate results instead of wrapping.
module h264invdc_transform #(
   parameter bit TOGETHER = 1'b0
) (
   input logic                   CLK,
   input logic                   RESET,
   h264invdc_transform_if.slave  bus
);

   typedef enum logic [1:0] {LOAD, CALC, OUT} state_t;

   state_t             state_q;
   logic [1:0]         icnt_q;
   logic [1:0]         ocnt_q;
   logic signed [15:0] c00_q;
   logic signed [15:0] c10_q;
   logic signed [17:0] f00_q, f01_q, f10_q, f11_q;
   logic signed [17:0] y00_q, y01_q, y10_q, y11_q;
   logic [15:0]        yy_q;
   logic               valid_q;

   logic               accept;
   logic               issue;
   logic signed [17:0] xin_w;
   logic signed [17:0] c00_w;
   logic signed [17:0] c10_w;
   logic signed [17:0] ysel;
   logic [15:0]        yy_d;

   assign bus.READYI = (state_q == LOAD) & ~RESET;
   assign bus.VALID  = valid_q;
   assign bus.YYOUT  = yy_q;

   assign accept = bus.ENABLE & bus.READYI;
   assign issue  = (state_q == OUT) &
                   (bus.READYO | (TOGETHER & (ocnt_q != 2'd0)));

   assign xin_w = {{2{bus.XXIN[15]}}, bus.XXIN};
   assign c00_w = {{2{c00_q[15]}}, c00_q};
   assign c10_w = {{2{c10_q[15]}}, c10_q};

   always_comb begin
      ysel = y00_q;
      unique case (ocnt_q)
         2'd0: ysel = y00_q;
         2'd1: ysel = y01_q;
         2'd2: ysel = y10_q;
         2'd3: ysel = y11_q;
      endcase
   end

`ifdef H264_INVDC_SATURATE_EN
   always_comb begin
      yy_d = ysel[15:0];
      if (ysel > 18'sd32767)
         yy_d = 16'h7FFF;
      else if (ysel < -18'sd32768)
         yy_d = 16'h8000;
   end
`else
   assign yy_d = ysel[15:0];
`endif

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= LOAD;
         icnt_q  <= 2'd0;
         ocnt_q  <= 2'd0;
         c00_q   <= '0;
         c10_q   <= '0;
         f00_q   <= '0;
         f01_q   <= '0;
         f10_q   <= '0;
         f11_q   <= '0;
         y00_q   <= '0;
         y01_q   <= '0;
         y10_q   <= '0;
         y11_q   <= '0;
         yy_q    <= '0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         unique case (state_q)
            LOAD: begin
               if (accept) begin
                  icnt_q <= icnt_q + 2'd1;
                  // Row stage folds in as each pair completes.
                  unique case (icnt_q)
                     2'd0: c00_q <= bus.XXIN;
                     2'd1: begin
                        f00_q <= c00_w + xin_w;
                        f01_q <= c00_w - xin_w;
                     end
                     2'd2: c10_q <= bus.XXIN;
                     2'd3: begin
                        f10_q   <= c10_w + xin_w;
                        f11_q   <= c10_w - xin_w;
                        state_q <= CALC;
                     end
                  endcase
               end
            end
            CALC: begin
               y00_q   <= f00_q + f10_q;
               y01_q   <= f01_q + f11_q;
               y10_q   <= f00_q - f10_q;
               y11_q   <= f01_q - f11_q;
               ocnt_q  <= 2'd0;
               state_q <= OUT;
            end
            OUT: begin
               if (issue) begin
                  yy_q    <= yy_d;
                  valid_q <= 1'b1;
                  ocnt_q  <= ocnt_q + 2'd1;
                  if (ocnt_q == 2'd3)
                     state_q <= LOAD;
               end
            end
            default: state_q <= LOAD;
         endcase
      end
   end

endmodule

// File: tb/tb_h264invdc_transform.sv
// Bench: two instances (TOGETHER=0/1) sharing stimulus, scoreboard per DUT.
module tb_h264invdc_transform;

   logic CLK = 1'b0;
   logic RESET;
   int   nchk  = 0;
   int   npass = 0;

   logic [15:0] q0[$];
   logic [15:0] q1[$];

   h264invdc_transform_if ifa0 ();
   h264invdc_transform_if ifa1 ();

   h264invdc_transform #(.TOGETHER(1'b0)) dut0 (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (ifa0)
   );

   h264invdc_transform #(.TOGETHER(1'b1)) dut1 (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (ifa1)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [15:0] obs,
                      input logic [15:0] exp);
      nchk++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [15:0] red(input int v);
`ifdef H264_INVDC_SATURATE_EN
      if (v > 32767) return 16'h7FFF;
      if (v < -32768) return 16'h8000;
`endif
      return v[15:0];
   endfunction

   task automatic push_exp(input int a, input int b, input int c, input int d);
      logic [15:0] e [4];
      e[0] = red(a + b + c + d);
      e[1] = red(a - b + c - d);
      e[2] = red(a + b - c - d);
      e[3] = red(a - b - c + d);
      for (int i = 0; i < 4; i++) begin
         q0.push_back(e[i]);
         q1.push_back(e[i]);
      end
   endtask

   task automatic drive(input logic en, input int x);
      ifa0.ENABLE = en;
      ifa1.ENABLE = en;
      ifa0.XXIN   = 16'(x);
      ifa1.XXIN   = 16'(x);
   endtask

   task automatic set_ro(input logic r);
      ifa0.READYO = r;
      ifa1.READYO = r;
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_drain();
      int n = 0;
      while (!(q0.size() == 0 && q1.size() == 0 &&
               ifa0.READYI && ifa1.READYI) && n < 100) begin
         tick();
         n++;
      end
      chk("drain_timeout", 16'(n < 100), 16'd1);
   endtask

   task automatic send(input int a, input int b, input int c, input int d);
      int v [4];
      v[0] = a; v[1] = b; v[2] = c; v[3] = d;
      for (int i = 0; i < 4; i++) begin
         chk("send_ready", {15'd0, ifa0.READYI & ifa1.READYI}, 16'd1);
         drive(1'b1, v[i]);
         tick();
      end
      drive(1'b0, 0);
      push_exp(a, b, c, d);
   endtask

   always @(negedge CLK) begin
      if (!RESET && ifa0.VALID) begin
         chk("sb0_nonempty", 16'(q0.size() > 0), 16'd1);
         if (q0.size() > 0) chk("sb0_data", ifa0.YYOUT, q0.pop_front());
      end
   end

   always @(negedge CLK) begin
      if (!RESET && ifa1.VALID) begin
         chk("sb1_nonempty", 16'(q1.size() > 0), 16'd1);
         if (q1.size() > 0) chk("sb1_data", ifa1.YYOUT, q1.pop_front());
      end
   end

   initial begin
      int n;
      RESET = 1'b1;
      drive(1'b0, 0);
      set_ro(1'b1);
      tick();
      tick();
      chk("rst_readyi", {15'd0, ifa0.READYI}, 16'd0);
      chk("rst_valid", {15'd0, ifa0.VALID}, 16'd0);
      chk("rst_yyout", ifa0.YYOUT, 16'd0);
      chk("rst_yyout1", ifa1.YYOUT, 16'd0);
      RESET = 1'b0;
      #1;
      chk("post_rst_readyi", {15'd0, ifa0.READYI}, 16'd1);

      // basic latency and values
      send(1, 2, 3, 4);
      tick();
      chk("lat_calc_valid", {15'd0, ifa0.VALID}, 16'd0);
      tick();
      chk("lat_first_valid", {15'd0, ifa0.VALID}, 16'd1);
      chk("lat_y00", ifa0.YYOUT, 16'd10);
      chk("out_readyi", {15'd0, ifa0.READYI}, 16'd0);
      tick();
      chk("lat_y01", ifa0.YYOUT, 16'hFFFE);
      tick();
      chk("lat_y10", ifa0.YYOUT, 16'hFFFC);
      tick();
      chk("lat_y11", ifa0.YYOUT, 16'h0000);
      chk("back_to_load", {15'd0, ifa0.READYI}, 16'd1);
      tick();
      chk("after_block_valid", {15'd0, ifa0.VALID}, 16'd0);
      wait_drain();

      // overflow boundary
      send(32767, 32767, 32767, 32767);
      tick();
      tick();
`ifdef H264_INVDC_SATURATE_EN
      chk("big_y00", ifa0.YYOUT, 16'h7FFF);
`else
      chk("big_y00", ifa0.YYOUT, 16'hFFFC);
`endif
      wait_drain();

      // downstream stall with TOGETHER=0
      send(7, -3, 2, 5);
      n = 0;
      while (!ifa0.VALID && n < 10) begin
         tick();
         n++;
      end
      chk("stall_first_seen", {15'd0, ifa0.VALID}, 16'd1);
      set_ro(1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_valid", {15'd0, ifa0.VALID}, 16'd0);
         chk("stall_readyi", {15'd0, ifa0.READYI}, 16'd0);
      end
      set_ro(1'b1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_resume", {15'd0, ifa0.VALID}, 16'd1);
      end
      wait_drain();

      // TOGETHER=1 ignores READYO after first output
      send(1, 2, 3, 4);
      n = 0;
      while (!ifa1.VALID && n < 10) begin
         tick();
         n++;
      end
      chk("tog_first_seen", {15'd0, ifa1.VALID}, 16'd1);
      set_ro(1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("tog_burst", {15'd0, ifa1.VALID}, 16'd1);
         chk("tog0_held", {15'd0, ifa0.VALID}, 16'd0);
      end
      set_ro(1'b1);
      wait_drain();

      // reset mid-block discards partial input
      drive(1'b1, 9);
      tick();
      drive(1'b1, 11);
      tick();
      drive(1'b0, 0);
      RESET = 1'b1;
      tick();
      chk("mid_rst_readyi", {15'd0, ifa0.READYI}, 16'd0);
      chk("mid_rst_valid", {15'd0, ifa0.VALID}, 16'd0);
      RESET = 1'b0;
      #1;
      chk("mid_rst_ready_back", {15'd0, ifa0.READYI}, 16'd1);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("mid_rst_no_valid", {15'd0, ifa0.VALID}, 16'd0);
      end
      send(5, 0, 0, 0);
      wait_drain();

      // ENABLE held through OUT is ignored
      send(1, 1, 1, 1);
      drive(1'b1, 99);
      n = 0;
      tick();
      while (!(ifa0.READYI && ifa1.READYI) && n < 20) begin
         chk("busy_readyi", {15'd0, ifa0.READYI}, 16'd0);
         tick();
         n++;
      end
      drive(1'b0, 0);
      chk("busy_timeout", 16'(n < 20), 16'd1);
      send(2, 0, 0, 0);
      wait_drain();

      chk("q0_empty", 16'(q0.size()), 16'd0);
      chk("q1_empty", 16'(q1.size()), 16'd0);
      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule

// File: doc/h264invdc_transform.md
H264INVDC_TRANSFORM -- requirements
Module: h264invdc_transform

Interface
REQ-001 SHALL have parameter TOGETHER, default 0: 1 = once output of a block starts, all 4 values issue on consecutive cycles regardless of READYO.
REQ-002 SHALL have port CLK  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-004 SHALL have port READYI  output  1  high when a new input value can be accepted.
REQ-005 SHALL have port ENABLE  input  1  input value present on XXIN this cycle.
REQ-006 SHALL have port XXIN  input  16  signed chroma DC coefficient, raster order c00,c01,c10,c11.
REQ-007 SHALL have port VALID  output  1  YYOUT carries a result this cycle.
REQ-008 SHALL have port YYOUT  output  16  signed inverse-transformed DC value, raster order.
REQ-009 SHALL have port READYO  input  1  downstream can accept a value this cycle.

Function
REQ-010 SHALL accept an input only on a cycle with ENABLE=1 and READYI=1; ENABLE while READYI=0 is ignored and does not advance the input counter.
REQ-011 SHALL count accepted inputs with a 2-bit counter, wrapping 3->0; the 4th accepted input completes a block.
REQ-012 SHALL compute the row stage: f00=c00+c01, f01=c00-c01, f10=c10+c11, f11=c10-c11, held at 18-bit signed width.
REQ-013 SHALL compute the column stage: y00=f00+f10, y01=f01+f11, y10=f00-f10, y11=f01-f11, held at 18-bit signed width.
REQ-014 SHALL use a 3-state FSM: LOAD (READYI=1, collecting inputs), CALC (one cycle, column stage registered), OUT (READYI=0, issuing results).
REQ-015 SHALL transition LOAD->CALC on acceptance of the 4th input, CALC->OUT unconditionally, and OUT->LOAD in the cycle after the 4th output issues.
REQ-016 SHALL issue results in order y00,y01,y10,y11, one per cycle in OUT, on cycles where READYO=1, or where TOGETHER=1 and the output index is nonzero.
REQ-017 SHALL register YYOUT and VALID, so that with READYO=1 the first VALID occurs 3 cycles after the cycle the 4th input is accepted.
REQ-018 SHALL hold VALID=0 and keep YYOUT unchanged on stall cycles, with no output lost or repeated.
REQ-019 SHALL keep READYI=0 from CALC until the last output issues, so that a block is never overwritten while it is being emitted.
REQ-020 SHALL reduce each 18-bit result to 16 bits per REQ-026/027.

Reset
REQ-021 SHALL, while RESET=1, force READYI=0, VALID=0, YYOUT=0, FSM to LOAD, and both input and output counters to 0.
REQ-022 SHALL drive READYI=1 on the first cycle after RESET deasserts.
REQ-023 SHALL discard any partial or in-flight block on RESET mid-operation; no VALID may follow reset until 4 new inputs are accepted.
REQ-024 SHALL clear all internal f/y registers to 0 on reset.

Configuration
REQ-025 SHALL use macro H264_INVDC_SATURATE_EN to select the output reduction.
REQ-026 SHALL, when the macro is defined, saturate each result to [-32768, 32767].
REQ-027 SHALL, when the macro is undefined, truncate each result to bits [15:0] (two's-complement wrap).

Verification
REQ-028 SHALL cover: inputs 1,2,3,4 with READYO=1 -> VALID pulses with YYOUT 10,-2,-4,0 on 4 consecutive cycles, first VALID 3 cycles after the 4th input is accepted.
REQ-029 SHALL cover: inputs 32767 x4 -> y00 reads 32767 with H264_INVDC_SATURATE_EN defined, 0xFFFC without; the other 3 outputs read 0.
REQ-030 SHALL cover: TOGETHER=0, READYO dropped for 3 cycles after the first output -> VALID=0 during the gap, then -2,-4,0 in order; READYI=0 throughout.
REQ-031 SHALL cover: TOGETHER=1, READYO high only on the first output cycle -> all 4 outputs issue on consecutive cycles.
REQ-032 SHALL cover: RESET asserted after 2 inputs, then inputs 5,0,0,0 -> outputs 5,5,5,5 and no stale values.
REQ-033 SHALL cover: ENABLE held high during OUT -> those inputs ignored; the next block starts after READYI returns to 1.
